// File: rtl/ss_a2d_pkg.sv
// Shared types and default widths for the successive-sample A2D datapath
// and the conversion control that drives it.
package ss_a2d_pkg;

   localparam int DAC_W_DEF    = 10;
   localparam int SMP_LOG2_DEF = 3;

   typedef enum logic {
      RES_EMPTY,
      RES_FULL
   } res_state_t;

   typedef enum logic [2:0] {
      CNV_IDLE,
      CNV_RAMP,
      CNV_SAMPLE,
      CNV_ACCUM,
      CNV_DONE
   } cnv_state_t;

endpackage

// File: rtl/sat_cntr.sv
// Clear/increment counter that sticks at all-ones instead of wrapping.
module sat_cntr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/ss_a2d_dp.sv
// A2D datapath: DAC ramp counter, sample counter, averaging accumulator and
// a single-entry result holding register with overrun detection.
module ss_a2d_dp
   import ss_a2d_pkg::*;
#(
   parameter int DAC_W    = DAC_W_DEF,
   parameter int SMP_LOG2 = SMP_LOG2_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_dac,
   input  logic             inc_dac,
   input  logic             clr_smp,
   input  logic             inc_smp,
   input  logic             accum,
   input  logic             cnv_cmplt,
   input  logic             res_rd,
   output logic [DAC_W-1:0] dac,
   output logic             smp_eq_8,
   output logic [DAC_W-1:0] res,
   output logic             res_vld,
   output logic             ovr
);

   localparam int ACC_W = DAC_W + SMP_LOG2;

   logic [SMP_LOG2-1:0] smp_cnt;
   logic [ACC_W-1:0]    acc;
   res_state_t          state, state_nxt;

   sat_cntr #(.W(DAC_W)) u_dac_cntr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_dac),
      .inc   (inc_dac),
      .cnt   (dac)
   );

   sat_cntr #(.W(SMP_LOG2)) u_smp_cntr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_smp),
      .inc   (inc_smp),
      .cnt   (smp_cnt)
   );

   assign smp_eq_8 = (smp_cnt == {SMP_LOG2{1'b1}});

   // Accumulator is sized to hold 2^SMP_LOG2 full-scale codes without overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr_smp)
         acc <= '0;
      else if (accum)
         acc <= acc + {{SMP_LOG2{1'b0}}, dac};
   end

   // Dropping the low SMP_LOG2 bits gives the truncated mean
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         res <= '0;
      else if (cnv_cmplt)
         res <= acc[ACC_W-1:SMP_LOG2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= RES_EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RES_EMPTY: if (cnv_cmplt)            state_nxt = RES_FULL;
         RES_FULL:  if (res_rd && !cnv_cmplt) state_nxt = RES_EMPTY;
         default:                             state_nxt = RES_EMPTY;
      endcase
   end

   assign res_vld = (state == RES_FULL);

   // Overrun: a fresh result replaced one the consumer never acknowledged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovr <= 1'b0;
      else if (clr_smp)
         ovr <= 1'b0;
      else if (cnv_cmplt && res_vld && !res_rd)
         ovr <= 1'b1;
   end

endmodule
